// File: rtl/servo_bank.sv
// servo_bank: multi-channel hobby-servo PWM generator driven from one shared frame counter.
// Optional macro SERVO_BANK_SLEW_EN limits each channel's position change to STEP per frame.
module servo_bank #(
  parameter int CHANNELS      = 4,
  parameter int POS_W         = 8,
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_PULSE     = 50000,
  parameter int MAX_PULSE     = 100000,
  parameter int STEP          = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              wr_valid,
  output logic                                              wr_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
  input  logic [POS_W-1:0]                                  wr_pos,
  output logic                                              wr_err,
  input  logic [CHANNELS-1:0]                               ch_en,
  output logic [CHANNELS-1:0]                               servo,
  output logic                                              frame_start,
  output logic [CHANNELS-1:0]                               moving
);

  localparam int CTR_W   = $clog2(PERIOD_CYCLES);
  localparam int SCALE   = (MAX_PULSE - MIN_PULSE) / (2**POS_W - 1);
  localparam int WID_MAX = MIN_PULSE + (2**POS_W - 1) * SCALE;
  localparam int WID_W   = $clog2(WID_MAX + 1);

  localparam logic [POS_W-1:0] POS_MID  = POS_W'(2**(POS_W-1));
  localparam logic [WID_W-1:0] WID_RST  = WID_W'(MIN_PULSE + 2**(POS_W-1) * SCALE);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PERIOD_CYCLES - 1);

  if (CHANNELS < 1 || CHANNELS > 16 || STEP < 1 || PERIOD_CYCLES < 2) begin : g_bad_params
    $error("servo_bank: parameter out of range");
  end

  logic [CTR_W-1:0]    ctr;
  logic [POS_W-1:0]    target   [CHANNELS];
  logic [POS_W-1:0]    pos_next [CHANNELS];
  logic [WID_W-1:0]    width_q  [CHANNELS];
  logic [CHANNELS-1:0] en_q;
  logic                boundary;
  logic                accept;
  logic                chan_ok;

  assign boundary = (ctr == CTR_LAST);
  assign wr_ready = ~rst & ~boundary;
  assign accept   = wr_valid & wr_ready;
  assign chan_ok  = 32'(wr_chan) < 32'(CHANNELS);

`ifdef SERVO_BANK_SLEW_EN
  logic [POS_W-1:0] current [CHANNELS];

  always_comb begin
    moving = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pos_next[i] = current[i];
      moving[i]   = (current[i] != target[i]);
      if (target[i] > current[i]) begin
        if (int'(target[i] - current[i]) > STEP) pos_next[i] = current[i] + POS_W'(STEP);
        else                                      pos_next[i] = target[i];
      end else if (target[i] < current[i]) begin
        if (int'(current[i] - target[i]) > STEP) pos_next[i] = current[i] - POS_W'(STEP);
        else                                      pos_next[i] = target[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rst)           current[i] <= POS_MID;
      else if (boundary) current[i] <= pos_next[i];
    end
  end
`else
  // Without slew the position register is the target itself, sampled at the boundary.
  always_comb begin
    moving = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) pos_next[i] = target[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr         <= '0;
      en_q        <= '0;
      servo       <= '0;
      wr_err      <= 1'b0;
      frame_start <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        target[i]  <= POS_MID;
        width_q[i] <= WID_RST;
      end
    end else begin
      ctr         <= boundary ? '0 : ctr + CTR_W'(1);
      frame_start <= (ctr == '0);
      wr_err      <= accept & ~chan_ok;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (accept && chan_ok && 32'(wr_chan) == i) target[i] <= wr_pos;
        servo[i] <= en_q[i] & (32'(ctr) < 32'(width_q[i]));
        // Width and enable only change on the wrap edge so a pulse is never cut mid-frame.
        if (boundary)
          width_q[i] <= WID_W'(MIN_PULSE) + WID_W'(WID_W'(pos_next[i]) * WID_W'(SCALE));
      end
      if (boundary) en_q <= ch_en;
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Randomised scoreboard bench for servo_bank: a frame-level model queues expected pulse widths
// per frame; a monitor measures each frame's pulses and handshake outputs against it.
module tb_servo_bank;

  localparam int CH   = 5;
  localparam int PW   = 8;
  localparam int PER  = 1000;
  localparam int MINP = 50;
  localparam int MAXP = 305;
  localparam int STP  = 4;
  localparam int SC   = (MAXP - MINP) / 255;
  localparam int MID  = 128;

  typedef logic [CH-1:0][15:0] frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_chan;
  logic [PW-1:0] wr_pos;
  logic          wr_err;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] servo;
  logic          frame_start;
  logic [CH-1:0] moving;

  servo_bank #(
    .CHANNELS(CH), .POS_W(PW), .PERIOD_CYCLES(PER),
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .STEP(STP)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_pos(wr_pos), .wr_err(wr_err), .ch_en(ch_en),
    .servo(servo), .frame_start(frame_start), .moving(moving)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frames_checked = 0;

  // Reference model: frame position, targets, current positions, latched widths and enables.
  int     m_ctr = 0;
  int     tgt [CH];
  int     cur [CH];
  int     wid [CH];
  bit     en  [CH];
  bit     m_acc = 0;
  bit     exp_err = 0;
  frame_t exp_q [$];

  always @(posedge clk) begin
    frame_t fr;
    m_acc = 0;
    if (rst) begin
      m_ctr = 0;
      exp_err = 0;
      for (int i = 0; i < CH; i++) begin
        tgt[i] = MID; cur[i] = MID; wid[i] = MINP + MID * SC; en[i] = 0;
      end
    end else begin
      if (wr_valid && m_ctr != PER - 1) begin
        m_acc = 1;
        if (int'(wr_chan) < CH) tgt[wr_chan] = int'(wr_pos);
      end
      exp_err = m_acc && (int'(wr_chan) >= CH);
      if (m_ctr == 0) begin
        for (int i = 0; i < CH; i++) fr[i] = en[i] ? 16'(wid[i]) : 16'd0;
        exp_q.push_back(fr);
      end
      if (m_ctr == PER - 1) begin
        for (int i = 0; i < CH; i++) begin
`ifdef SERVO_BANK_SLEW_EN
          int d;
          d = tgt[i] - cur[i];
          if (d > STP)  d = STP;
          if (d < -STP) d = -STP;
          cur[i] = cur[i] + d;
`else
          cur[i] = tgt[i];
`endif
          wid[i] = MINP + cur[i] * SC;
          en[i]  = ch_en[i];
        end
        m_ctr = 0;
      end else begin
        m_ctr = m_ctr + 1;
      end
    end
  end

  // Monitor: per-cycle handshake checks plus per-frame pulse measurement.
  bit     in_frame = 0;
  int     k = 0;
  frame_t cur_exp;
  int     cnt [CH];
  bit     bad [CH];

  always @(negedge clk) begin
    logic [CH-1:0] exp_mv;
    tests++;
    if (wr_ready !== (!rst && m_ctr != PER - 1)) begin
      fails++;
      $display("FAIL wr_ready: got %b expected %b (model ctr %0d rst %b)", wr_ready, !rst && m_ctr != PER - 1, m_ctr, rst);
    end
    if (rst) begin
      in_frame = 0;
    end else begin
      tests++;
      if (wr_err !== exp_err) begin
        fails++;
        $display("FAIL wr_err: got %b expected %b (model ctr %0d)", wr_err, exp_err, m_ctr);
      end
      exp_mv = '0;
`ifdef SERVO_BANK_SLEW_EN
      for (int i = 0; i < CH; i++) exp_mv[i] = (cur[i] != tgt[i]);
`endif
      tests++;
      if (moving !== exp_mv) begin
        fails++;
        $display("FAIL moving: got %b expected %b (model ctr %0d)", moving, exp_mv, m_ctr);
      end
      if (!in_frame && !frame_start) begin
        tests++;
        if (servo !== '0) begin
          fails++;
          $display("FAIL servo_idle: got %b expected %b", servo, {CH{1'b0}});
        end
      end
      if (frame_start) begin
        if (in_frame) begin
          tests++;
          if (k != PER) begin
            fails++;
            $display("FAIL frame_len: got %0d expected %0d", k, PER);
          end
          for (int i = 0; i < CH; i++) begin
            tests++;
            if (cnt[i] != int'(cur_exp[i]) || bad[i]) begin
              fails++;
              $display("FAIL pulse_ch%0d: got %0d high cycles (misplaced=%b) expected %0d", i, cnt[i], bad[i], cur_exp[i]);
            end
          end
          frames_checked++;
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_queue: got frame_start with %0d expected frames queued, expected 1", exp_q.size());
          in_frame = 0;
        end else begin
          cur_exp = exp_q.pop_front();
          in_frame = 1;
          k = 0;
          for (int i = 0; i < CH; i++) begin cnt[i] = 0; bad[i] = 0; end
        end
      end
      if (in_frame) begin
        for (int i = 0; i < CH; i++) if (servo[i]) begin
          cnt[i]++;
          if (k >= int'(cur_exp[i])) bad[i] = 1;
        end
        k++;
        if (k > PER) begin
          tests++; fails++;
          $display("FAIL frame_start_missing: got %0d cycles without frame_start expected %0d", k, PER);
          in_frame = 0;
        end
      end
    end
  end

  task automatic wait_ctr(input int v);
    bit hit = 0;
    for (int t = 0; t < 2 * PER + 2; t++) begin
      @(posedge clk); #1;
      if (m_ctr == v) begin hit = 1; break; end
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL wait_ctr: got no ctr==%0d expected it within %0d cycles", v, 2 * PER + 2);
    end
  endtask

  task automatic do_write(input int ch, input int pos);
    bit ok = 0;
    wr_valid = 1; wr_chan = 3'(ch); wr_pos = PW'(pos);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (m_acc) begin ok = 1; break; end
    end
    wr_valid = 0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL write_accept: got no accept for ch %0d expected within 5 cycles", ch);
    end
  endtask

  initial begin
    #(10 * PER * 40);
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; wr_valid = 0; wr_chan = '0; wr_pos = '0; ch_en = '1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_ctr(0);
    wait_ctr(300);
    do_write(1, 255);
    do_write(5, 77);
    do_write(3, 0);
    do_write(3, 200);
    wait_ctr(PER - 1);
    do_write(2, 10);
    wait_ctr(500);
    do_write(0, 140);
    repeat (4) wait_ctr(500);
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(1, 200)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) ch_en = CH'($urandom);
      do_write($urandom_range(0, 7), $urandom_range(0, 255));
    end
    ch_en = '1;
    wait_ctr(0);
    wait_ctr(20);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    wait_ctr(0);
    wait_ctr(0);
    wait_ctr(500);
    tests++;
    if (frames_checked < 8) begin
      fails++;
      $display("FAIL frames_checked: got %0d expected at least 8", frames_checked);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
